// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI bridge between the fetch (imem) and data (dmem)
// requesters. Each port latches a one-cycle request pulse. The arbiter issues
// one request at a time and returns the bridge's rdata/ready to the granted
// port only.
// Ports:
//   clock, reset                 single clock, synchronous active-high reset
//   imem_valid/addr              fetch request pulse and address
//   imem_rdata/ready             fetch read data and completion pulse
//   dmem_valid/addr/wdata/wstrb  data request pulse and payload (wstrb=0: read)
//   dmem_rdata/ready             load data and completion pulse
//   axi_valid/instr/addr/wdata/wstrb  one-cycle request to the bridge
//   axi_rdata/ready              bridge read data and completion pulse
// ARB_MODE: 0 = fixed priority with dmem winning, 1 = round-robin on last grant.
module axi_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        axi_valid,
  output logic        axi_instr,
  output logic [31:0] axi_addr,
  output logic [31:0] axi_wdata,
  output logic [3:0]  axi_wstrb,
  input  logic [31:0] axi_rdata,
  input  logic        axi_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic        ipend, dpend;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dwstrb;
  // last_d is both the last-grant pointer and, while BUSY, the current grant.
  logic        last_d;
  logic        pick_d;
  logic        issue, done, idone, ddone;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        instr_q;

  always_comb begin
    pick_d = dpend;
    if (ipend && dpend) pick_d = (ARB_MODE == 0) ? 1'b1 : !last_d;
  end

  assign issue = (state == IDLE) && (ipend || dpend);
  assign done  = (state == BUSY) && axi_ready;
  assign idone = done && !last_d;
  assign ddone = done && last_d;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (ipend || dpend) state_nx = BUSY;
      BUSY: if (axi_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    axi_valid  = issue;
    axi_instr  = instr_q;
    axi_addr   = addr_q;
    axi_wdata  = wdata_q;
    axi_wstrb  = wstrb_q;
    if (issue) begin
      axi_instr = !pick_d;
      axi_addr  = pick_d ? daddr : iaddr;
      axi_wdata = pick_d ? dwdata : '0;
      axi_wstrb = pick_d ? dwstrb : '0;
    end
    imem_ready = idone;
    dmem_ready = ddone;
    imem_rdata = idone ? axi_rdata : '0;
    dmem_rdata = ddone ? axi_rdata : '0;
  end

  // A port may take a new request only when it is free or completing now.
  always_ff @(posedge clock) begin
    if (reset) begin
      ipend  <= 1'b0;
      dpend  <= 1'b0;
      iaddr  <= '0;
      daddr  <= '0;
      dwdata <= '0;
      dwstrb <= '0;
    end else begin
      if (imem_valid && (!ipend || idone)) begin
        ipend <= 1'b1;
        iaddr <= imem_addr;
      end else if (idone) begin
        ipend <= 1'b0;
      end
      if (dmem_valid && (!dpend || ddone)) begin
        dpend  <= 1'b1;
        daddr  <= dmem_addr;
        dwdata <= dmem_wdata;
        dwstrb <= dmem_wstrb;
      end else if (ddone) begin
        dpend <= 1'b0;
      end
    end
  end

  // The issued payload is held so the bridge sees it stable through BUSY.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_d  <= 1'b0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (issue) begin
      last_d  <= pick_d;
      instr_q <= !pick_d;
      addr_q  <= pick_d ? daddr : iaddr;
      wdata_q <= pick_d ? dwdata : '0;
      wstrb_q <= pick_d ? dwstrb : '0;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
module tb_axi_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        dmem_valid;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;

  logic [31:0] imem_rdata [2];
  logic        imem_ready [2];
  logic [31:0] dmem_rdata [2];
  logic        dmem_ready [2];
  logic        axi_valid  [2];
  logic        axi_instr  [2];
  logic [31:0] axi_addr   [2];
  logic [31:0] axi_wdata  [2];
  logic [3:0]  axi_wstrb  [2];
  logic [31:0] axi_rdata  [2];
  logic        axi_ready  [2];

  axi_arbiter #(.ARB_MODE(0)) dut0 (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata[0]), .imem_ready(imem_ready[0]),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata[0]), .dmem_ready(dmem_ready[0]),
    .axi_valid(axi_valid[0]), .axi_instr(axi_instr[0]), .axi_addr(axi_addr[0]),
    .axi_wdata(axi_wdata[0]), .axi_wstrb(axi_wstrb[0]),
    .axi_rdata(axi_rdata[0]), .axi_ready(axi_ready[0])
  );

  axi_arbiter #(.ARB_MODE(1)) dut1 (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata[1]), .imem_ready(imem_ready[1]),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata[1]), .dmem_ready(dmem_ready[1]),
    .axi_valid(axi_valid[1]), .axi_instr(axi_instr[1]), .axi_addr(axi_addr[1]),
    .axi_wdata(axi_wdata[1]), .axi_wstrb(axi_wstrb[1]),
    .axi_rdata(axi_rdata[1]), .axi_ready(axi_ready[1])
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Transaction-level model per arbiter: what each port has outstanding,
  // which port owns the bridge, and what payload it was given.
  bit          m_ipend [2];
  bit          m_dpend [2];
  logic [31:0] m_iaddr [2];
  logic [31:0] m_daddr [2];
  logic [31:0] m_dwdata[2];
  logic [3:0]  m_dwstrb[2];
  bit          m_busy  [2];
  bit          m_own_d [2];   // port owning the bridge, 1 = dmem
  bit          m_last_d[2];   // last granted port, 1 = dmem
  logic [31:0] m_haddr [2];
  logic [31:0] m_hwdata[2];
  logic [3:0]  m_hwstrb[2];
  int unsigned m_cnt   [2];   // cycles until the bench's bridge answers
  bit          post_rst;

  initial begin
    bit          rst_now;
    bit          give, gd, ci, cd;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;

    reset = 1'b1;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    post_rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      axi_ready[k] = 1'b0; axi_rdata[k] = '0;
      m_ipend[k] = 0; m_dpend[k] = 0; m_busy[k] = 0; m_own_d[k] = 0;
      m_last_d[k] = 0; m_cnt[k] = 0;
      m_iaddr[k] = '0; m_daddr[k] = '0; m_dwdata[k] = '0; m_dwstrb[k] = '0;
      m_haddr[k] = '0; m_hwdata[k] = '0; m_hwstrb[k] = '0;
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clock); #1;
      rst_now = (cyc < 2) || ($urandom_range(0, 199) == 0);
      reset = rst_now;
      imem_valid = !rst_now && ($urandom_range(0, 99) < 35);
      imem_addr  = $urandom;
      dmem_valid = !rst_now && ($urandom_range(0, 99) < 35);
      dmem_addr  = $urandom;
      dmem_wdata = $urandom;
      dmem_wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      for (int k = 0; k < 2; k++) begin
        axi_rdata[k] = $urandom;
        if (rst_now) axi_ready[k] = 1'b0;
        else if (m_busy[k]) begin
          if (m_cnt[k] > 1) begin
            m_cnt[k]--;
            axi_ready[k] = 1'b0;
          end else axi_ready[k] = 1'b1;
        end else axi_ready[k] = ($urandom_range(0, 9) == 0); // must be ignored
      end

      @(negedge clock);
      for (int k = 0; k < 2; k++) begin
        give = 0; gd = 0; ci = 0; cd = 0;
        if (post_rst) begin
          check($sformatf("m%0d_rst_instr", k), 32'(axi_instr[k]), 32'd0);
          check($sformatf("m%0d_rst_addr", k), axi_addr[k], 32'd0);
          check($sformatf("m%0d_rst_wdata", k), axi_wdata[k], 32'd0);
          check($sformatf("m%0d_rst_wstrb", k), 32'(axi_wstrb[k]), 32'd0);
        end
        if (!m_busy[k]) begin
          if (m_ipend[k] || m_dpend[k]) begin
            give = 1;
            if (m_ipend[k] && m_dpend[k]) gd = (k == 0) ? 1'b1 : !m_last_d[k];
            else gd = m_dpend[k];
            e_addr  = gd ? m_daddr[k] : m_iaddr[k];
            e_wdata = m_dwdata[k];
            e_wstrb = gd ? m_dwstrb[k] : 4'h0;
            check($sformatf("m%0d_grant_instr", k), 32'(axi_instr[k]), 32'(!gd));
            check($sformatf("m%0d_grant_addr", k), axi_addr[k], e_addr);
            check($sformatf("m%0d_grant_wstrb", k), 32'(axi_wstrb[k]), 32'(e_wstrb));
            if (gd) check($sformatf("m%0d_grant_wdata", k), axi_wdata[k], e_wdata);
          end
        end else begin
          check($sformatf("m%0d_hold_instr", k), 32'(axi_instr[k]), 32'(!m_own_d[k]));
          check($sformatf("m%0d_hold_addr", k), axi_addr[k], m_haddr[k]);
          check($sformatf("m%0d_hold_wstrb", k), 32'(axi_wstrb[k]), 32'(m_hwstrb[k]));
          if (m_own_d[k]) check($sformatf("m%0d_hold_wdata", k), axi_wdata[k], m_hwdata[k]);
          if (axi_ready[k]) begin
            cd = m_own_d[k];
            ci = !m_own_d[k];
          end
        end
        check($sformatf("m%0d_axi_valid", k), 32'(axi_valid[k]), 32'(give));
        check($sformatf("m%0d_imem_ready", k), 32'(imem_ready[k]), 32'(ci));
        check($sformatf("m%0d_dmem_ready", k), 32'(dmem_ready[k]), 32'(cd));
        check($sformatf("m%0d_imem_rdata", k), imem_rdata[k], ci ? axi_rdata[k] : 32'd0);
        check($sformatf("m%0d_dmem_rdata", k), dmem_rdata[k], cd ? axi_rdata[k] : 32'd0);

        if (rst_now) begin
          m_ipend[k] = 0; m_dpend[k] = 0; m_busy[k] = 0; m_last_d[k] = 0;
          m_cnt[k] = 0; m_haddr[k] = '0; m_hwdata[k] = '0; m_hwstrb[k] = '0;
        end else begin
          if (give) begin
            m_busy[k] = 1; m_own_d[k] = gd; m_last_d[k] = gd;
            m_haddr[k] = e_addr; m_hwdata[k] = e_wdata; m_hwstrb[k] = e_wstrb;
            m_cnt[k] = $urandom_range(1, 4);
          end
          if (ci || cd) m_busy[k] = 0;
          if (ci) m_ipend[k] = 0;
          if (cd) m_dpend[k] = 0;
          if (imem_valid && !m_ipend[k]) begin
            m_ipend[k] = 1; m_iaddr[k] = imem_addr;
          end
          if (dmem_valid && !m_dpend[k]) begin
            m_dpend[k] = 1; m_daddr[k] = dmem_addr;
            m_dwdata[k] = dmem_wdata; m_dwstrb[k] = dmem_wstrb;
          end
        end
      end
      post_rst = rst_now;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
